// File: rtl/y_rr_mux.sv
// y_rr_mux: N-channel, SIZE-bit arbitrating multiplexer with one registered output stage.
// The select comes from an internal arbiter: round-robin (mode=0) or fixed priority,
// lowest index first (mode=1).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/in_valid  NCH packed input channels (channel i at [i*SIZE +: SIZE]) and requests
//   in_ready          per-channel accept, one-hot or zero, combinational
//   mode              0 = round-robin, 1 = fixed priority
//   out_data/out_sel  registered selected word and the index of its source channel
//   out_valid         out_data/out_sel hold a word
//   out_ready         consumer accepts the word
module y_rr_mux #(
  parameter  int unsigned SIZE = 32,
  parameter  int unsigned NCH  = 4,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH*SIZE-1:0] in_data,
  input  logic [NCH-1:0]      in_valid,
  output logic [NCH-1:0]      in_ready,
  input  logic                mode,
  output logic [SIZE-1:0]     out_data,
  output logic [SELW-1:0]     out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  // One extra bit so that start + offset cannot overflow before the modulo-NCH fold
  localparam int unsigned CW = SELW + 1;

  logic [SELW-1:0] r_ptr;
  logic [SIZE-1:0] r_data;
  logic [SELW-1:0] r_sel;
  logic            r_valid;

  logic            w_load_en;
  logic            w_found;
  logic            w_xfer;
  logic [NCH-1:0]  w_grant;
  logic [SELW-1:0] w_gidx;
  logic [SELW-1:0] w_start;
  logic [SELW-1:0] w_ptr_nxt;
  logic [CW-1:0]   w_cand;
  logic [SIZE-1:0] w_gdata;

  // Output register can take a word when empty or being drained this cycle
  assign w_load_en = !r_valid || out_ready;

  // Fixed priority is a round-robin search that always starts at channel 0
  assign w_start = mode ? '0 : r_ptr;

  // Arbiter: first requesting channel found walking from w_start, wrapping at NCH
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_cand = {1'b0, w_start} + CW'(k);
      if (w_cand >= CW'(NCH)) begin
        w_cand = w_cand - CW'(NCH);
      end
      if (!w_found && in_valid[w_cand[SELW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_cand[SELW-1:0];
      end
    end
    if (w_found) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  // One-hot AND-OR data mux driven by the grant vector
  always_comb begin
    w_gdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_grant[i]) begin
        w_gdata = w_gdata | in_data[i*SIZE +: SIZE];
      end
    end
  end

  assign w_xfer    = w_found && w_load_en;
  assign w_ptr_nxt = (w_gidx == SELW'(NCH - 1)) ? '0 : w_gidx + SELW'(1);

  // Accepts are suppressed while reset is asserted
  assign in_ready = (w_load_en && rst_n) ? w_grant : '0;

  // Output stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_data  <= w_gdata;
      r_sel   <= w_gidx;
      r_valid <= 1'b1;
      if (!mode) begin
        r_ptr <= w_ptr_nxt;
      end
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_y_rr_mux.sv
// Testbench for y_rr_mux: a 4-channel instance exercised by directed scenarios and random
// traffic against a behavioural model, plus a 3-channel instance for the modulo-NCH wrap.
module tb_y_rr_mux;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic         out_ready;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [127:0] in_data;
  logic [31:0]  ch_data [4];
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid;

  logic         mode3;
  logic         out_ready3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [95:0]  in_data3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_valid3;

  int n_vec;
  int n_err;

  // Behavioural model of the 4-channel instance
  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_sel;

  assign in_data  = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
  assign in_data3 = {32'hA2, 32'hA1, 32'hA0};

  y_rr_mux #(.SIZE(32), .NCH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  y_rr_mux #(.SIZE(32), .NCH(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (mode3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winning channel under the arbitration rules, or -1 when nobody requests
  function automatic int ref_grant(input logic [15:0] v, input bit fp, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = fp ? k : (ptr + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = ref_grant({12'd0, in_valid}, mode, m_ptr, 4);
    if (rst_n && (!m_valid || out_ready) && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_sel   = 0;
  endtask

  task automatic model_edge();
    int g;
    if (!rst_n) return;
    g = ref_grant({12'd0, in_valid}, mode, m_ptr, 4);
    if ((!m_valid || out_ready) && g >= 0) begin
      m_data  = ch_data[g];
      m_sel   = g;
      m_valid = 1'b1;
      if (!mode) m_ptr = (g + 1) % 4;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; out_ready = 1'b0; in_valid = 4'b1111;
    in_valid3 = 3'b000; out_ready3 = 1'b1; mode3 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h expected 0", out_data); end
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b expected 0000", in_ready); end
    rst_n = 1'b1; in_valid = 4'b0100;
    #1;
    n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL rst_load_ready: got %b expected 0100", in_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'hA2) begin n_err++; $display("FAIL rst_load: got v=%b d=%h expected v=1 d=a2", out_valid, out_data); end
    @(negedge clk);
    in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin n_err++; $display("FAIL rst_async: got v=%b d=%h s=%0d expected 0/0/0", out_valid, out_data, out_sel); end
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rst_async_ready: got %b expected 0000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 4'b0001; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_grant: got %b expected 0001", in_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hA0) begin n_err++; $display("FAIL rst_first_out: got v=%b s=%0d d=%h expected 1/0/a0", out_valid, out_sel, out_data); end
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      n_vec++; if (in_ready !== 4'(1 << (k % 4))) begin n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << (k % 4))); end
      tick();
      n_vec++; if (out_sel !== 2'(k % 4) || out_data !== 32'hA0 + 32'(k % 4) || out_valid !== 1'b1) begin n_err++; $display("FAIL rr_out[%0d]: got s=%0d d=%h v=%b expected s=%0d d=%h v=1", k, out_sel, out_data, out_valid, k % 4, 32'hA0 + 32'(k % 4)); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, in_ready); end
      tick();
      n_vec++; if (out_sel !== 2'd0 || out_data !== 32'hA0 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d]: got s=%0d d=%h v=%b expected 0/a0/1", k, out_sel, out_data, out_valid); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release: got %b expected 0010", in_ready); end
    tick();
    n_vec++; if (out_sel !== 2'd1 || out_data !== 32'hA1) begin n_err++; $display("FAIL bp_release_out: got s=%0d d=%h expected 1/a1", out_sel, out_data); end
  endtask

  task automatic test_fixed_priority();
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      n_vec++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL fp_ready[%0d]: got %b expected 0010", k, in_ready); end
      tick();
      n_vec++; if (out_sel !== 2'd1 || out_data !== 32'hA1) begin n_err++; $display("FAIL fp_out[%0d]: got s=%0d d=%h expected 1/a1", k, out_sel, out_data); end
    end
    @(negedge clk);
    mode = 1'b0; in_valid = 4'b1111;
    #1;
    n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fp_resume: got %b expected 0100", in_ready); end
    tick();
    n_vec++; if (out_sel !== 2'd2) begin n_err++; $display("FAIL fp_resume_out: got %0d expected 2", out_sel); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    in_valid = 4'b1000;
    #1;
    n_vec++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_ch3: got %b expected 1000", in_ready); end
    tick();
    @(negedge clk);
    in_valid = 4'b0100;
    #1;
    n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL wrap_sparse: got %b expected 0100", in_ready); end
    tick();
    n_vec++; if (out_sel !== 2'd2 || out_data !== 32'hA2) begin n_err++; $display("FAIL wrap_sparse_out: got s=%0d d=%h expected 2/a2", out_sel, out_data); end
    @(negedge clk);
    in_valid = 4'b1111;
    #1;
    n_vec++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_ptr3: got %b expected 1000", in_ready); end
    tick();
    @(negedge clk);
    in_valid = 4'b0000;
    in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      n_vec++; if (in_ready3 !== 3'(1 << (k % 3))) begin n_err++; $display("FAIL wrap3_ready[%0d]: got %b expected %b", k, in_ready3, 3'(1 << (k % 3))); end
      tick();
      n_vec++; if (out_sel3 !== 2'(k % 3) || out_data3 !== 32'hA0 + 32'(k % 3)) begin n_err++; $display("FAIL wrap3_out[%0d]: got s=%0d d=%h expected s=%0d", k, out_sel3, out_data3, k % 3); end
    end
    @(negedge clk);
    in_valid3 = 3'b000;
  endtask

  task automatic test_drain_load();
    in_valid = 4'b0001;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_sel !== 2'd0) begin n_err++; $display("FAIL dl_prime: got v=%b s=%0d expected 1/0", out_valid, out_sel); end
    @(negedge clk);
    in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL dl_ready: got %b expected 0100", in_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'hA2) begin n_err++; $display("FAIL dl_load: got v=%b s=%0d d=%h expected 1/2/a2", out_valid, out_sel, out_data); end
    @(negedge clk);
    in_valid = 4'b0000;
    tick();
    n_vec++; if (out_valid !== 1'b0 || out_sel !== 2'd2 || out_data !== 32'hA2) begin n_err++; $display("FAIL dl_drain: got v=%b s=%0d d=%h expected 0/2/a2", out_valid, out_sel, out_data); end
  endtask

  task automatic test_random();
    logic [3:0] er;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      in_valid  = 4'($urandom);
      mode      = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) ch_data[i] = $urandom;
      #1;
      er = exp_ready();
      n_vec++; if (in_ready !== er) begin n_err++; $display("FAIL rand_ready[%0d]: got %b expected %b", k, in_ready, er); end
      tick();
      n_vec++; if (out_valid !== m_valid || out_sel !== 2'(m_sel) || out_data !== m_data) begin n_err++; $display("FAIL rand_out[%0d]: got v=%b s=%0d d=%h expected v=%b s=%0d d=%h", k, out_valid, out_sel, out_data, m_valid, m_sel, m_data); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) ch_data[i] = 32'hA0 + 32'(i);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fixed_priority();
    test_wrap();
    test_drain_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/y_rr_mux.md
Name: y_rr_mux

Overview:
- Parametrised N-channel, SIZE-bit arbitrating multiplexer with a registered output stage.
- Generalises the combinational yMux family: the select is generated internally by a round-robin or fixed-priority arbiter instead of being an input.
- Each input channel has a valid/ready handshake, and the output has one too.
- Sits between multiple producers (e.g. ALU/load result sources) and a single shared consumer or writeback path.

Parameters:
- SIZE, 32, data width of each channel and of the output.
- NCH, 4, number of input channels; legal values are 2 to 16, and values that are not a power of two are legal.
- SELW, $clog2(NCH), width of the channel index; derived and not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NCH*SIZE  channel i occupies bits [i*SIZE +: SIZE].
- in_valid  input  NCH  per-channel request.
- in_ready  output  NCH  per-channel accept; at most one bit is high in any cycle.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_data  output  SIZE  registered selected word.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid = 0, out_data = 0, out_sel = 0.
  - Round-robin pointer ptr = 0.
  - in_ready is forced to 0 while rst_n is low.
  - Reset mid-transfer discards the held word; no partial state survives.
- Output stage:
  - load_en = !out_valid || out_ready.
  - Single register, no skid buffer.
- Arbitration (combinational, evaluated every cycle):
  - The grant is one-hot, and all-zero when in_valid == 0.
  - mode 0: search indices ptr, ptr+1, ... NCH-1, 0, ... ptr-1 and take the first with in_valid set. The wrap is modulo NCH, not 2^SELW.
  - mode 1: the lowest set index of in_valid wins; ptr is ignored.
  - in_ready[i] = load_en && grant[i].
  - in_ready may depend combinationally on in_valid and out_ready. in_valid must not depend on in_ready.
- Transfer on clk when in_valid[g] && in_ready[g]:
  - out_data <= channel g, out_sel <= g, out_valid <= 1.
  - Latency is 1 cycle from accept to out_valid.
  - Throughput is 1 word per cycle while out_ready = 1.
- Pointer update:
  - mode 0: on a transfer, ptr <= (g == NCH-1) ? 0 : g+1.
  - mode 1: ptr holds its value. Switching mode mid-stream is legal, and round-robin resumes from the held ptr.
- Drain: out_valid && out_ready with no grant gives out_valid <= 0. out_data and out_sel hold their last values.
- Stall: out_valid && !out_ready gives in_ready = 0 for all channels. out_data, out_sel and ptr are stable.
- Simultaneous drain and load: out_valid && out_ready with a grant loads the new word in the same edge. out_valid stays 1 with no bubble cycle.
- Starvation: in mode 0, any continuously valid channel is granted within NCH transfers.
- No X propagation: out_data changes only on a transfer or on reset.

Test Plan (NCH=4, SIZE=32; channel i data = 32'hA0 + i unless stated):
1. Reset: load a word (out_valid = 1, out_data = 32'hA2), then drop rst_n between clock edges -> out_valid, out_data and out_sel go to 0 immediately without a clock edge. After release with in_valid = 4'b0001 -> ch0 is granted first (ptr = 0).
2. Round-robin fairness: mode = 0, in_valid = 4'b1111, out_ready = 1 for 5 cycles -> in_ready one-hot sequence 0001, 0010, 0100, 1000, 0001. out_sel follows one cycle later: 0, 1, 2, 3, 0, with out_data A0, A1, A2, A3, A0.
3. Backpressure: hold out_ready = 0 for 3 cycles while out_valid = 1 and in_valid = 4'b1111 -> in_ready = 0, and out_data, out_sel and ptr are unchanged. Raise out_ready -> the next channel after the held out_sel is granted in that same cycle.
4. Fixed priority: mode = 1, in_valid = 4'b1010 for 4 cycles with out_ready = 1 -> ch1 is granted every cycle and ch3 never. Return to mode = 0 -> round-robin resumes from the ptr held before mode 1.
5. Wrap and sparse requests: mode 0, after a ch3 grant (ptr = 0) set in_valid = 4'b0100 -> ch2 is granted and the next ptr = 3. Repeat with NCH = 3 (in_valid = 3'b111) -> grant order 0, 1, 2, 0, confirming the wrap is modulo NCH.
6. Simultaneous drain and load: out_valid = 1, out_ready = 1 and in_valid = 4'b0100 in the same cycle -> out_data = 32'hA2 and out_sel = 2 next cycle, with out_valid held at 1. Then set in_valid = 0 with out_ready = 1 -> out_valid = 0 next cycle and out_data holds 32'hA2.
